zx_ram_bridge: RTL

Requester-side bridge between the 8-bit Spectrum CPU/ULA memory bus and one toggle-handshake 16-bit port of the SDRAM controller. It converts single byte reads and writes into word-wide port accesses, selecting the byte lane from address bit 0. A one-word read buffer answers repeated reads of the same word without an SDRAM access. It is write-through and stays coherent with its own writes.

---
 rtl/zx_ram_pkg.sv | 20 ++
 rtl/zx_ram_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/zx_ram_pkg.sv
// Shared types and helpers for the Spectrum-bus to SDRAM-port bridge.
package zx_ram_pkg;

    // Bridge sequencing: idle, answering from the read buffer, or waiting on the port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIT  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Port byte enables; bit 1 is the upper byte of the 16-bit word.
    localparam logic [1:0] DS_LO = 2'b01;
    localparam logic [1:0] DS_HI = 2'b10;

    // Pick the byte addressed by a0 out of a 16-bit word (odd address = upper byte).
    function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic a0);
        return a0 ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/zx_ram_bridge.sv
// Byte-wide CPU/ULA bus to toggle-handshake 16-bit SDRAM port, with a
// one-word write-through read buffer.
module zx_ram_bridge
    import zx_ram_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    output logic          cpu_busy,
    output logic          cpu_done,
    input  logic          flush,
    output logic          ram_req,
    input  logic          ram_ack,
    output logic          ram_we,
    output logic [AW-2:0] ram_a,
    output logic [1:0]    ram_ds,
    output logic [15:0]   ram_d,
    input  logic [15:0]   ram_q
);

    state_t        state_q, state_d;
    // The request toggle is never reset: it must stay in step with the
    // controller, which only knows its power-up value.
    logic          ram_req_q = 1'b0;
    logic          ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-2:0] ram_a_q, ram_a_d;
    logic [1:0]    ram_ds_q, ram_ds_d;
    logic [15:0]   ram_d_q, ram_d_d;
    logic [15:0]   buf_q, buf_d;
    logic [AW-2:0] tag_q, tag_d;
    logic          valid_q, valid_d;
    logic          lane_q, lane_d;
    logic [7:0]    cpu_q_q, cpu_q_d;
    logic          cpu_done_q, cpu_done_d;

    logic          pending;
    logic          busy;
    logic          hit;
    logic [15:0]   merged;

    assign pending = (ram_req_q != ram_ack);
    assign busy    = (state_q != IDLE) | pending;
    assign hit     = valid_q && (tag_q == cpu_a[AW-1:1]);

    // Buffer word with the lanes of the completed write patched in.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign merged[gi*8 +: 8] = ram_ds_q[gi] ? ram_d_q[gi*8 +: 8] : buf_q[gi*8 +: 8];
    end

    // Next-state and next-output computation for the access sequencer and buffer.
    always_comb begin
        state_d    = state_q;
        ram_req_d  = ram_req_q;
        ram_we_d   = ram_we_q;
        ram_a_d    = ram_a_q;
        ram_ds_d   = ram_ds_q;
        ram_d_d    = ram_d_q;
        buf_d      = buf_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        lane_d     = lane_q;
        cpu_q_d    = cpu_q_q;
        cpu_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req && !busy) begin
                    lane_d = cpu_a[0];
                    if (!cpu_we && hit) begin
                        state_d = HIT;
                    end else begin
                        state_d   = WAIT;
                        ram_req_d = ~ram_req_q;
                        ram_we_d  = cpu_we;
                        ram_a_d   = cpu_a[AW-1:1];
                        ram_ds_d  = cpu_a[0] ? DS_HI : DS_LO;
                        ram_d_d   = {cpu_d, cpu_d};
                    end
                end
            end
            HIT: begin
                state_d    = IDLE;
                cpu_done_d = 1'b1;
                cpu_q_d    = lane_sel(buf_q, lane_q);
            end
            WAIT: begin
                if (!pending) begin
                    state_d    = IDLE;
                    cpu_done_d = 1'b1;
                    if (!ram_we_q) begin
                        buf_d   = ram_q;
                        tag_d   = ram_a_q;
                        valid_d = 1'b1;
                        cpu_q_d = lane_sel(ram_q, lane_q);
                    end else if (valid_q && (tag_q == ram_a_q)) begin
                        buf_d = merged;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over a fill landing on the same edge.
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // State register; port fields are only cleared by reset when no request is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            cpu_done_q <= 1'b0;
            cpu_q_q    <= 8'h00;
            if (!pending) begin
                ram_we_q <= 1'b0;
                ram_a_q  <= '0;
                ram_ds_q <= 2'b00;
                ram_d_q  <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            ram_req_q  <= ram_req_d;
            ram_we_q   <= ram_we_d;
            ram_a_q    <= ram_a_d;
            ram_ds_q   <= ram_ds_d;
            ram_d_q    <= ram_d_d;
            buf_q      <= buf_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            lane_q     <= lane_d;
            cpu_q_q    <= cpu_q_d;
            cpu_done_q <= cpu_done_d;
        end
    end

    assign cpu_q    = cpu_q_q;
    assign cpu_done = cpu_done_q;
    assign cpu_busy = busy;
    assign ram_req  = ram_req_q;
    assign ram_we   = ram_we_q;
    assign ram_a    = ram_a_q;
    assign ram_ds   = ram_ds_q;
    assign ram_d    = ram_d_q;

endmodule
